// File: rtl/esm_pkg.sv
// Shared types and constants for the ESM dependency scoreboard.
// Holds the entry-state encoding, instruction field positions and a clog2 helper.
package esm_pkg;

   typedef enum logic [1:0] {
      E_FREE   = 2'd0,
      E_WAIT   = 2'd1,
      E_READY  = 2'd2,
      E_ISSUED = 2'd3
   } entry_state_e;

   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int RD_LSB  = 7;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/esm_prio_enc.sv
// Lowest-set-bit priority encoder with an any-set flag.
// Used for both free-slot selection and ready-entry selection.
module esm_prio_enc
   import esm_pkg::*;
#(
   parameter  int N = 16,
   localparam int W = (N > 1) ? clog2(N) : 1
) (
   input  logic [N-1:0] i_req,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx = i[W-1:0];
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/esm_dep_scoreboard.sv
// ESM dependency scoreboard: allocates buffer slots, tracks RAW dependencies on
// in-flight producers, retires completions and offers READY entries for issue.
module esm_dep_scoreboard
   import esm_pkg::*;
#(
   parameter  int INSTR_W  = 32,
   parameter  int REGNUM   = 32,
   parameter  int BS       = 16,
   parameter  int NCMP     = 2,
   parameter  int X0_NODEP = 1,
   localparam int RW       = clog2(REGNUM),
   localparam int IW       = clog2(BS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               alloc_valid,
   output logic               alloc_ready,
   output logic [IW-1:0]      alloc_index,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               alu_src,
   input  logic               reg_write,
   input  logic [NCMP-1:0]    cmp_valid,
   input  logic [NCMP*IW-1:0] cmp_index,
   output logic               issue_valid,
   output logic [IW-1:0]      issue_index,
   input  logic               issue_ready,
   output logic [IW:0]        occupancy
);

   // Handshakes: alloc transfers when alloc_valid && alloc_ready; issue transfers when
   // issue_valid && issue_ready, and issue_index is held stable until that transfer.

   // Per-entry state array is the scoreboard's FSM state, visible to bound checkers.
   entry_state_e         r_state        [BS];
   entry_state_e         w_state_nxt    [BS];
   logic [BS-1:0]        r_dep          [BS];
   logic [BS-1:0]        w_dep_nxt      [BS];
   logic [REGNUM-1:0]    r_ptab_v;
   logic [REGNUM-1:0]    w_ptab_v_nxt;
   logic [IW-1:0]        r_ptab_idx     [REGNUM];
   logic [IW-1:0]        w_ptab_idx_nxt [REGNUM];
   logic                 r_issue_valid;
   logic                 w_issue_valid_nxt;
   logic [IW-1:0]        r_issue_index;
   logic [IW-1:0]        w_issue_index_nxt;
   logic [IW:0]          r_occ;
   logic [IW:0]          w_occ_nxt;

   logic [BS-1:0]        w_free_vec;
   logic [BS-1:0]        w_rdy_vec;
   logic [BS-1:0]        w_slot_mask;
   logic [BS-1:0]        w_cmp_hit;
   logic [BS-1:0]        w_cmp_mask;
   logic [BS-1:0]        w_dep_new;
   logic [IW:0]          w_cmp_cnt;
   logic [IW-1:0]        w_free_idx;
   logic [IW-1:0]        w_rdy_idx;
   logic                 w_free_any;
   logic                 w_rdy_any;
   logic                 w_alloc_fire;
   logic                 w_accept;
   logic [RW-1:0]        w_rs1;
   logic [RW-1:0]        w_rs2;
   logic [RW-1:0]        w_rd;
   logic                 w_rs1_x0;
   logic                 w_rs2_x0;
   logic                 w_rd_x0;
   logic                 w_unused_instr;

   assign w_rs1          = instr_in[RS1_LSB +: RW];
   assign w_rs2          = instr_in[RS2_LSB +: RW];
   assign w_rd           = instr_in[RD_LSB +: RW];
   assign w_rs1_x0       = (X0_NODEP != 0) && (w_rs1 == '0);
   assign w_rs2_x0       = (X0_NODEP != 0) && (w_rs2 == '0);
   assign w_rd_x0        = (X0_NODEP != 0) && (w_rd == '0);
   assign w_unused_instr = ^instr_in;

   assign w_alloc_fire = alloc_valid && w_free_any && !flush;
   assign w_accept     = r_issue_valid && issue_ready;

   always_comb begin
      w_slot_mask = '0;
      if (r_issue_valid) w_slot_mask[r_issue_index] = 1'b1;
      for (int i = 0; i < BS; i++) begin
         w_free_vec[i] = (r_state[i] == E_FREE);
         w_rdy_vec[i]  = (r_state[i] == E_READY) && !w_slot_mask[i];
      end
   end

   esm_prio_enc #(.N(BS)) u_free_sel (
      .i_req (w_free_vec),
      .o_idx (w_free_idx),
      .o_any (w_free_any)
   );

   esm_prio_enc #(.N(BS)) u_rdy_sel (
      .i_req (w_rdy_vec),
      .o_idx (w_rdy_idx),
      .o_any (w_rdy_any)
   );

   // Duplicate indices collapse into one hit; strobes on non-ISSUED entries are dropped.
   always_comb begin
      w_cmp_hit = '0;
      for (int k = 0; k < NCMP; k++) begin
         if (cmp_valid[k]) w_cmp_hit[cmp_index[k*IW +: IW]] = 1'b1;
      end
      w_cmp_cnt = '0;
      for (int i = 0; i < BS; i++) begin
         w_cmp_mask[i] = w_cmp_hit[i] && (r_state[i] == E_ISSUED);
         w_cmp_cnt     = w_cmp_cnt + {{IW{1'b0}}, w_cmp_mask[i]};
      end
   end

   // Producers retiring this cycle are filtered out so no stale dependency is recorded.
   always_comb begin
      w_dep_new = '0;
      if (r_ptab_v[w_rs1] && !w_rs1_x0) w_dep_new[r_ptab_idx[w_rs1]] = 1'b1;
      if (alu_src && r_ptab_v[w_rs2] && !w_rs2_x0) w_dep_new[r_ptab_idx[w_rs2]] = 1'b1;
      w_dep_new = w_dep_new & ~w_cmp_mask;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BS; i++) begin
            r_state[i] <= E_FREE;
            r_dep[i]   <= '0;
         end
         for (int r = 0; r < REGNUM; r++) r_ptab_idx[r] <= '0;
         r_ptab_v      <= '0;
         r_issue_valid <= 1'b0;
         r_issue_index <= '0;
         r_occ         <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_dep         <= w_dep_nxt;
         r_ptab_v      <= w_ptab_v_nxt;
         r_ptab_idx    <= w_ptab_idx_nxt;
         r_issue_valid <= w_issue_valid_nxt;
         r_issue_index <= w_issue_index_nxt;
         r_occ         <= w_occ_nxt;
      end
   end

   always_comb begin
      for (int i = 0; i < BS; i++) begin
         w_state_nxt[i] = r_state[i];
         w_dep_nxt[i]   = r_dep[i] & ~w_cmp_mask;
         case (r_state[i])
            E_WAIT:   if (w_dep_nxt[i] == '0) w_state_nxt[i] = E_READY;
            E_READY:  if (w_accept && (r_issue_index == i[IW-1:0])) w_state_nxt[i] = E_ISSUED;
            E_ISSUED: if (w_cmp_mask[i]) w_state_nxt[i] = E_FREE;
            default: begin
               if (w_alloc_fire && (w_free_idx == i[IW-1:0])) begin
                  w_state_nxt[i] = (w_dep_new != '0) ? E_WAIT : E_READY;
                  w_dep_nxt[i]   = w_dep_new;
               end
            end
         endcase
      end

      // A same-cycle write to rd wins over invalidation by a retiring producer.
      w_ptab_v_nxt = r_ptab_v;
      for (int r = 0; r < REGNUM; r++) begin
         w_ptab_idx_nxt[r] = r_ptab_idx[r];
         if (r_ptab_v[r] && w_cmp_mask[r_ptab_idx[r]]) w_ptab_v_nxt[r] = 1'b0;
      end
      if (w_alloc_fire && reg_write && !w_rd_x0) begin
         w_ptab_v_nxt[w_rd]   = 1'b1;
         w_ptab_idx_nxt[w_rd] = w_free_idx;
      end

      w_issue_valid_nxt = r_issue_valid;
      w_issue_index_nxt = r_issue_index;
      if (!r_issue_valid || w_accept) begin
         w_issue_valid_nxt = w_rdy_any;
         if (w_rdy_any) w_issue_index_nxt = w_rdy_idx;
      end

      w_occ_nxt = r_occ + {{IW{1'b0}}, w_alloc_fire} - w_cmp_cnt;

      if (flush) begin
         for (int i = 0; i < BS; i++) begin
            w_state_nxt[i] = E_FREE;
            w_dep_nxt[i]   = '0;
         end
         for (int r = 0; r < REGNUM; r++) w_ptab_idx_nxt[r] = '0;
         w_ptab_v_nxt      = '0;
         w_issue_valid_nxt = 1'b0;
         w_issue_index_nxt = '0;
         w_occ_nxt         = '0;
      end
   end

   always_comb begin
      alloc_ready = w_free_any;
      alloc_index = w_free_idx;
      issue_valid = r_issue_valid;
      issue_index = r_issue_index;
      occupancy   = r_occ;
   end

endmodule

// File: tb/tb_esm_dep_scoreboard.sv
// Bench for esm_dep_scoreboard: directed scenarios followed by random traffic,
// every cycle compared against a slot/producer-table reference model.
module tb_esm_dep_scoreboard;

   localparam int INSTR_W  = 32;
   localparam int REGNUM   = 32;
   localparam int BS       = 16;
   localparam int NCMP     = 2;
   localparam int IW       = 4;
   localparam int S_FREE   = 0;
   localparam int S_WAIT   = 1;
   localparam int S_READY  = 2;
   localparam int S_ISSUED = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               flush;
   logic               alloc_valid;
   logic               alloc_ready;
   logic [IW-1:0]      alloc_index;
   logic [INSTR_W-1:0] instr_in;
   logic               alu_src;
   logic               reg_write;
   logic [NCMP-1:0]    cmp_valid;
   logic [NCMP*IW-1:0] cmp_index;
   logic               issue_valid;
   logic [IW-1:0]      issue_index;
   logic               issue_ready;
   logic [IW:0]        occupancy;

   int n_cmp = 0;
   int n_bad = 0;

   int m_st   [BS];
   bit m_dep  [BS][BS];
   int m_prod [REGNUM];
   bit m_iv;
   int m_ii;

   always #5 clk = ~clk;

   esm_dep_scoreboard dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .alloc_valid (alloc_valid),
      .alloc_ready (alloc_ready),
      .alloc_index (alloc_index),
      .instr_in    (instr_in),
      .alu_src     (alu_src),
      .reg_write   (reg_write),
      .cmp_valid   (cmp_valid),
      .cmp_index   (cmp_index),
      .issue_valid (issue_valid),
      .issue_index (issue_index),
      .issue_ready (issue_ready),
      .occupancy   (occupancy)
   );

   function automatic logic [31:0] mk_instr(input int rd, input int rs1, input int rs2);
      logic [4:0] a, b, c;
      a = rd[4:0];
      b = rs1[4:0];
      c = rs2[4:0];
      return {7'h00, c, b, 3'b000, a, 7'h33};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < BS; i++) begin
         m_st[i] = S_FREE;
         for (int j = 0; j < BS; j++) m_dep[i][j] = 1'b0;
      end
      for (int r = 0; r < REGNUM; r++) m_prod[r] = -1;
      m_iv = 1'b0;
      m_ii = 0;
   endfunction

   function automatic int m_free_idx();
      for (int i = 0; i < BS; i++) if (m_st[i] == S_FREE) return i;
      return -1;
   endfunction

   function automatic int m_occ();
      int n;
      n = 0;
      for (int i = 0; i < BS; i++) if (m_st[i] != S_FREE) n++;
      return n;
   endfunction

   // Advance the reference by one clock using the inputs currently driven.
   function automatic void model_step();
      int fi, sel, rd, rs1, rs2;
      bit fire, acc, any_nd, clear;
      bit done [BS];
      bit nd   [BS];
      fi   = m_free_idx();
      fire = alloc_valid && (fi >= 0);
      acc  = m_iv && issue_ready;
      for (int i = 0; i < BS; i++) begin
         done[i] = 1'b0;
         nd[i]   = 1'b0;
      end
      for (int k = 0; k < NCMP; k++) begin
         if (cmp_valid[k]) begin
            int e;
            e = int'(cmp_index[k*IW +: IW]);
            if (m_st[e] == S_ISSUED) done[e] = 1'b1;
         end
      end
      sel = -1;
      for (int i = BS - 1; i >= 0; i--)
         if (m_st[i] == S_READY && !(m_iv && i == m_ii)) sel = i;
      if (flush) begin
         model_reset();
         return;
      end
      rd  = int'(instr_in[11:7]);
      rs1 = int'(instr_in[19:15]);
      rs2 = int'(instr_in[24:20]);
      if (rs1 != 0 && m_prod[rs1] >= 0 && !done[m_prod[rs1]]) nd[m_prod[rs1]] = 1'b1;
      if (alu_src && rs2 != 0 && m_prod[rs2] >= 0 && !done[m_prod[rs2]]) nd[m_prod[rs2]] = 1'b1;
      for (int e = 0; e < BS; e++) begin
         if (done[e]) begin
            m_st[e] = S_FREE;
            for (int j = 0; j < BS; j++) m_dep[j][e] = 1'b0;
            for (int r = 0; r < REGNUM; r++) if (m_prod[r] == e) m_prod[r] = -1;
         end
      end
      for (int j = 0; j < BS; j++) begin
         if (m_st[j] == S_WAIT) begin
            clear = 1'b1;
            for (int e = 0; e < BS; e++) if (m_dep[j][e]) clear = 1'b0;
            if (clear) m_st[j] = S_READY;
         end
      end
      if (acc) m_st[m_ii] = S_ISSUED;
      if (fire) begin
         any_nd = 1'b0;
         for (int e = 0; e < BS; e++) begin
            m_dep[fi][e] = nd[e];
            any_nd = any_nd | nd[e];
         end
         m_st[fi] = any_nd ? S_WAIT : S_READY;
         if (reg_write && rd != 0) m_prod[rd] = fi;
      end
      if (!m_iv || acc) begin
         m_iv = (sel >= 0);
         if (sel >= 0) m_ii = sel;
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int fi;
      fi = m_free_idx();
      check("alloc_ready", {31'd0, alloc_ready}, (fi >= 0) ? 32'd1 : 32'd0);
      if (fi >= 0) check("alloc_index", {28'd0, alloc_index}, fi);
      check("issue_valid", {31'd0, issue_valid}, {31'd0, m_iv});
      if (m_iv) check("issue_index", {28'd0, issue_index}, m_ii);
      check("occupancy", {27'd0, occupancy}, m_occ());
   endtask

   task automatic clear_inputs();
      flush       = 1'b0;
      alloc_valid = 1'b0;
      instr_in    = '0;
      alu_src     = 1'b0;
      reg_write   = 1'b0;
      cmp_valid   = '0;
      cmp_index   = '0;
      issue_ready = 1'b0;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic set_cmp(input int k, input int idx);
      cmp_valid[k]          = 1'b1;
      cmp_index[k*IW +: IW] = idx[IW-1:0];
   endtask

   task automatic do_alloc(input int rd, input int rs1, input int rs2, input bit src, input bit wr);
      alloc_valid = 1'b1;
      instr_in    = mk_instr(rd, rs1, rs2);
      alu_src     = src;
      reg_write   = wr;
      cycle();
      alloc_valid = 1'b0;
      instr_in    = '0;
      alu_src     = 1'b0;
      reg_write   = 1'b0;
   endtask

   // Accept and retire everything in flight, bounded by a cycle budget.
   task automatic drain();
      for (int c = 0; c < 300; c++) begin
         int n;
         if (m_occ() == 0) break;
         clear_inputs();
         issue_ready = 1'b1;
         n = 0;
         for (int e = 0; e < BS; e++) begin
            if (m_st[e] == S_ISSUED && n < NCMP) begin
               set_cmp(n, e);
               n++;
            end
         end
         cycle();
      end
      clear_inputs();
      check("drain_occupancy", {27'd0, occupancy}, 32'd0);
   endtask

   initial begin
      clear_inputs();
      model_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_occupancy",   {27'd0, occupancy},   32'd0);
      check("rst_alloc_ready", {31'd0, alloc_ready}, 32'd1);
      check("rst_alloc_index", {28'd0, alloc_index}, 32'd0);
      check("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
      check("rst_issue_index", {28'd0, issue_index}, 32'd0);
      rst = 1'b1;

      // x1 = x2 + x3 with no producers: READY at t+1, offered at t+2.
      check("t1_alloc_index", {28'd0, alloc_index}, 32'd0);
      do_alloc(1, 2, 3, 1'b1, 1'b1);
      check("t1_iv_t1", {31'd0, issue_valid}, 32'd0);
      cycle();
      check("t1_iv_t2",  {31'd0, issue_valid}, 32'd1);
      check("t1_idx_t2", {28'd0, issue_index}, 32'd0);
      drain();

      // RAW on x5: dependant waits for producer completion, then issues two cycles later.
      do_alloc(5, 1, 2, 1'b1, 1'b1);
      check("t2_e1_index", {28'd0, alloc_index}, 32'd1);
      do_alloc(6, 5, 0, 1'b0, 1'b1);
      check("t2_iv_e0",  {31'd0, issue_valid}, 32'd1);
      check("t2_idx_e0", {28'd0, issue_index}, 32'd0);
      issue_ready = 1'b1;
      cycle();
      issue_ready = 1'b0;
      check("t2_e1_waiting", {31'd0, issue_valid}, 32'd0);
      set_cmp(0, 0);
      cycle();
      clear_inputs();
      check("t2_cmp_t1", {31'd0, issue_valid}, 32'd0);
      cycle();
      check("t2_cmp_t2_valid", {31'd0, issue_valid}, 32'd1);
      check("t2_cmp_t2_index", {28'd0, issue_index}, 32'd1);
      drain();

      // Producer retires in the same cycle its consumer is allocated: no dependency.
      do_alloc(5, 1, 2, 1'b1, 1'b1);
      cycle();
      issue_ready = 1'b1;
      cycle();
      issue_ready = 1'b0;
      check("t4_alloc_index", {28'd0, alloc_index}, 32'd1);
      set_cmp(0, 0);
      alloc_valid = 1'b1;
      instr_in    = mk_instr(0, 5, 0);
      cycle();
      clear_inputs();
      check("t4_occupancy", {27'd0, occupancy},   32'd1);
      check("t4_iv_t1",     {31'd0, issue_valid}, 32'd0);
      cycle();
      check("t4_iv_t2",  {31'd0, issue_valid}, 32'd1);
      check("t4_idx_t2", {28'd0, issue_index}, 32'd1);
      drain();

      // Fill all slots, then an extra alloc must be ignored.
      for (int i = 0; i < BS; i++) do_alloc(0, 0, 0, 1'b0, 1'b0);
      check("t3_full_ready", {31'd0, alloc_ready}, 32'd0);
      check("t3_full_occ",   {27'd0, occupancy},   32'd16);
      alloc_valid = 1'b1;
      instr_in    = mk_instr(3, 0, 0);
      reg_write   = 1'b1;
      cycle();
      clear_inputs();
      check("t3_ignored_occ",   {27'd0, occupancy},   32'd16);
      check("t3_ignored_ready", {31'd0, alloc_ready}, 32'd0);

      // Two completions in one cycle (e2, e7).
      issue_ready = 1'b1;
      for (int c = 0; c < 40 && m_st[7] != S_ISSUED; c++) cycle();
      issue_ready = 1'b0;
      check("t5_occ_pre", {27'd0, occupancy}, 32'd16);
      set_cmp(0, 2);
      set_cmp(1, 7);
      cycle();
      clear_inputs();
      check("t5_occ",         {27'd0, occupancy},   32'd14);
      check("t5_alloc_index", {28'd0, alloc_index}, 32'd2);
      check("t5_alloc_ready", {31'd0, alloc_ready}, 32'd1);
      drain();

      // Held issue slot while a lower entry becomes READY, then flush.
      do_alloc(5, 1, 2, 1'b1, 1'b1);
      cycle();
      issue_ready = 1'b1;
      cycle();
      issue_ready = 1'b0;
      check("t6_e1_index", {28'd0, alloc_index}, 32'd1);
      do_alloc(0, 5, 0, 1'b0, 1'b0);
      check("t6_e2_index", {28'd0, alloc_index}, 32'd2);
      do_alloc(0, 0, 0, 1'b0, 1'b0);
      cycle();
      check("t6_slot_valid", {31'd0, issue_valid}, 32'd1);
      check("t6_slot_index", {28'd0, issue_index}, 32'd2);
      set_cmp(0, 0);
      cycle();
      clear_inputs();
      for (int c = 0; c < 5; c++) begin
         cycle();
         check("t6_hold_valid", {31'd0, issue_valid}, 32'd1);
         check("t6_hold_index", {28'd0, issue_index}, 32'd2);
      end
      flush       = 1'b1;
      alloc_valid = 1'b1;
      instr_in    = mk_instr(4, 0, 0);
      reg_write   = 1'b1;
      issue_ready = 1'b1;
      cycle();
      clear_inputs();
      check("t6_flush_occ",   {27'd0, occupancy},   32'd0);
      check("t6_flush_iv",    {31'd0, issue_valid}, 32'd0);
      check("t6_flush_index", {28'd0, alloc_index}, 32'd0);
      check("t6_flush_ready", {31'd0, alloc_ready}, 32'd1);
      cycle();
      check("t6_flush_iv_after", {31'd0, issue_valid}, 32'd0);

      // Random traffic against the reference model.
      for (int c = 0; c < 600; c++) begin
         int iss_q[$];
         alloc_valid = ($urandom_range(0, 99) < 55);
         instr_in    = mk_instr($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
         alu_src     = 1'($urandom_range(0, 1));
         reg_write   = 1'($urandom_range(0, 1));
         issue_ready = ($urandom_range(0, 99) < 60);
         flush       = ($urandom_range(0, 299) == 0);
         cmp_valid   = '0;
         cmp_index   = '0;
         iss_q.delete();
         for (int e = 0; e < BS; e++) if (m_st[e] == S_ISSUED) iss_q.push_back(e);
         for (int k = 0; k < NCMP; k++) begin
            if (iss_q.size() > 0 && $urandom_range(0, 99) < 45)
               set_cmp(k, iss_q[$urandom_range(0, iss_q.size() - 1)]);
         end
         cycle();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
